// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and defaults for the HI/LO multiply/divide sequencer
package mdu_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 5;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} mdu_state_e;
endpackage

// File: rtl/hilo_mdu_seq_if.sv
// hilo_mdu_seq_if: request/result bundle between the control FSM (master) and the MDU (slave)
//   start/op/rs_data/rt_data/flush : master -> MDU
//   busy/done/HI_Q/LO_Q            : MDU -> master
interface hilo_mdu_seq_if #(parameter int DATA_W = mdu_pkg::DATA_W);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] HI_Q;
  logic [DATA_W-1:0] LO_Q;
  modport master (output start, op, rs_data, rt_data, flush, input busy, done, HI_Q, LO_Q);
  modport slave (input start, op, rs_data, rt_data, flush, output busy, done, HI_Q, LO_Q);
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
//   is_div : select divide step
//   acc    : product (mul) or {remainder, quotient} (div)
//   m64    : multiplicand pre-shifted to the current bit weight (mul only)
//   b      : remaining multiplier bits (mul) or divisor (div)
//   *_n    : next values
module mdu_iter_step #(parameter int DATA_W = mdu_pkg::DATA_W) (
  input  logic                is_div,
  input  logic [2*DATA_W-1:0] acc,
  input  logic [2*DATA_W-1:0] m64,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] acc_n,
  output logic [2*DATA_W-1:0] m64_n,
  output logic [DATA_W-1:0]   b_n
);
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] rem;
  logic              ge;
  always_comb begin
    part  = acc[2*DATA_W-1:DATA_W-1];
    ge    = part >= {1'b0, b};
    // when ge the difference is below the divisor, so the carry bit is dropped safely
    rem   = part[DATA_W-1:0] - b;
    acc_n = is_div ? (ge ? {rem, acc[DATA_W-2:0], 1'b1} : {acc[2*DATA_W-2:0], 1'b0})
                   : acc + (b[0] ? m64 : '0);
    m64_n = is_div ? m64 : {m64[2*DATA_W-2:0], 1'b0};
    b_n   = is_div ? b : b >> 1;
  end
endmodule

// File: rtl/hilo_mdu_seq.sv
// hilo_mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus single-cycle MTHI/MTLO
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hilo_mdu_seq_if slave (start/op/rs_data/rt_data/flush in, busy/done/HI_Q/LO_Q out)
//   MDU_EARLY_OUT_EN : when defined, multiplies finish as soon as the remaining multiplier bits are zero
module hilo_mdu_seq #(
  parameter int DATA_W = mdu_pkg::DATA_W,
  parameter int CNT_W  = mdu_pkg::CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  hilo_mdu_seq_if.slave bus
);
  import mdu_pkg::*;
  mdu_state_e          state;
  mdu_op_e             op_q;
  logic [DATA_W-1:0]   rs_q, rt_q, b_q, hi_q, lo_q, abs_rs, abs_rt;
  logic [DATA_W-1:0]   b_n, quo, rem, fix_hi, fix_lo;
  logic [2*DATA_W-1:0] acc, m64, acc_n, m64_n, prod;
  logic [CNT_W-1:0]    cnt;
  logic                q_neg, r_neg, done_q, is_div, is_sgn, div0, calc_last;
  assign is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign is_sgn = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign abs_rs = (is_sgn && rs_q[DATA_W-1]) ? -rs_q : rs_q;
  assign abs_rt = (is_sgn && rt_q[DATA_W-1]) ? -rt_q : rt_q;
  assign div0   = rt_q == '0;
  assign prod   = q_neg ? -acc : acc;
  assign quo    = q_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem    = r_neg ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  // divide by zero reports the raw dividend and all-ones, independent of sign fixup
  assign fix_hi = !is_div ? prod[2*DATA_W-1:DATA_W] : div0 ? rs_q : rem;
  assign fix_lo = !is_div ? prod[DATA_W-1:0] : div0 ? DIV0_LO : quo;
`ifdef MDU_EARLY_OUT_EN
  // the multiplicand is pre-shifted each step, so an exhausted multiplier means acc is final
  assign calc_last = (cnt == CNT_W'(DATA_W-1)) || (!is_div && b_n == '0);
`else
  assign calc_last = cnt == CNT_W'(DATA_W-1);
`endif
  mdu_iter_step #(.DATA_W(DATA_W)) u_step (
    .is_div(is_div), .acc(acc), .m64(m64), .b(b_q),
    .acc_n(acc_n), .m64_n(m64_n), .b_n(b_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= MDU_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      b_q    <= '0;
      acc    <= '0;
      m64    <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && bus.flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.op[2]) begin
              op_q  <= mdu_op_e'(bus.op);
              rs_q  <= bus.rs_data;
              rt_q  <= bus.rt_data;
              state <= S_PREP;
            end
            if (bus.start && bus.op == MDU_MTHI) hi_q <= bus.rs_data;
            if (bus.start && bus.op == MDU_MTLO) lo_q <= bus.rs_data;
          end
          S_PREP: begin
            q_neg <= is_sgn && (rs_q[DATA_W-1] ^ rt_q[DATA_W-1]);
            r_neg <= is_sgn && rs_q[DATA_W-1];
            acc   <= is_div ? {{DATA_W{1'b0}}, abs_rs} : '0;
            m64   <= {{DATA_W{1'b0}}, abs_rs};
            b_q   <= abs_rt;
            cnt   <= '0;
            state <= S_CALC;
          end
          S_CALC: begin
            acc   <= acc_n;
            m64   <= m64_n;
            b_q   <= b_n;
            cnt   <= cnt + CNT_W'(1);
            state <= calc_last ? S_FIX : S_CALC;
          end
          S_FIX: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
  assign bus.busy = state != S_IDLE;
  assign bus.done = done_q;
  assign bus.HI_Q = hi_q;
  assign bus.LO_Q = lo_q;
endmodule

// File: tb/tb_hilo_mdu_seq.sv
// tb_hilo_mdu_seq: directed vector table plus hand sequences for flush, reset and ignored starts
module tb_hilo_mdu_seq;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int bc, dn;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;
  vec_t vecs[10];
  hilo_mdu_seq_if #(.DATA_W(32)) bus ();
  hilo_mdu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int exp_busy(input logic [2:0] op, input logic [31:0] rt);
    logic [31:0] m;
    int n;
    m = (op == 3'b000 && rt[31]) ? -rt : rt;
    n = 0;
    do begin
      m = m >> 1;
      n++;
    end while (m != 0 && n < 32);
`ifdef MDU_EARLY_OUT_EN
    return op[1] ? 34 : n + 2;
`else
    return (n > 0) ? 34 : 0;
`endif
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs_data = ~rs;
    bus.rt_data = rt ^ 32'h5A5A_0F0F;
  endtask
  task automatic wait_idle(output int b, output int d);
    b = 0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      d += int'(bus.done);
      if (!bus.busy) break;
      b++;
    end
    @(negedge clk);
    d += int'(bus.done);
  endtask
  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    vecs[5] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{3'd1, 32'd7,         32'd3,          32'd0,         32'd21};
    vecs[7] = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000,  32'hC000_0000, 32'h8000_0000};
    vecs[8] = '{3'd3, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999};
    vecs[9] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 3'b110;
    bus.rs_data = '0;
    bus.rt_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(bus.HI_Q), 64'd0);
    chk("reset_lo", 64'(bus.LO_Q), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_idle(bc, dn);
      chk($sformatf("v%0d_hi", i), 64'(bus.HI_Q), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(bus.LO_Q), 64'(vecs[i].lo));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(exp_busy(vecs[i].op, vecs[i].rt)));
      chk($sformatf("v%0d_done_pulses", i), 64'(dn), 64'd1);
    end
    issue(3'd4, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_hi", 64'(bus.HI_Q), 64'hA5A5_A5A5);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    issue(3'd5, 32'h0BAD_F00D, 32'd0);
    chk("mtlo_lo", 64'(bus.LO_Q), 64'h0BAD_F00D);
    chk("mtlo_hi_kept", 64'(bus.HI_Q), 64'hA5A5_A5A5);
    issue(3'd6, 32'hCAFE_0000, 32'd9);
    chk("nop_busy", 64'(bus.busy), 64'd0);
    chk("nop_hi", 64'(bus.HI_Q), 64'hA5A5_A5A5);
    chk("nop_lo", 64'(bus.LO_Q), 64'h0BAD_F00D);
    issue(3'd1, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.rs_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle(bc, dn);
    chk("busy_mtlo_lo", 64'(bus.LO_Q), 64'd12);
    chk("busy_mtlo_hi", 64'(bus.HI_Q), 64'd0);
    chk("busy_mtlo_done", 64'(dn), 64'd1);
    issue(3'd4, 32'h0000_1111, 32'd0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    chk("flush_done", 64'(dn), 64'd0);
    chk("flush_hi", 64'(bus.HI_Q), 64'h0000_1111);
    chk("flush_lo", 64'(bus.LO_Q), 64'd12);
    @(negedge clk);
    bus.flush = 1'b1;
    issue(3'd1, 32'd2, 32'd3);
    bus.flush = 1'b0;
    chk("idle_flush_start_busy", 64'(bus.busy), 64'd1);
    wait_idle(bc, dn);
    chk("idle_flush_start_lo", 64'(bus.LO_Q), 64'd6);
    chk("idle_flush_start_done", 64'(dn), 64'd1);
    issue(3'd4, 32'h0000_0077, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(bus.HI_Q), 64'd0);
    chk("midrst_lo", 64'(bus.LO_Q), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'(bus.busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
